// File: rtl/icache_m0_fill_ctrl.sv
// Instruction-side (master 0) cache controller: sequences tag read, hit
// check and data read, and on a miss fetches the 128-bit line with a
// 4-beat AXI4 INCR read burst before returning the requested word.
module icache_m0_fill_ctrl #(
   parameter logic [3:0] M0_ID = 4'd0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cpu_req,
   input  logic [31:0]   i_cpu_addr,
   output logic          o_done,
   output logic [31:0]   o_inst,
   output logic          o_busy,
   output logic          o_bus_err,
   output logic [3:0]    o_m0_state,
   output logic [31:0]   o_cpu_a,
   input  logic          i_m0_hit,
   input  logic [127:0]  i_cache_do,
   output logic [127:0]  o_line,
   output logic [3:0]    ARID,
   output logic [31:0]   ARADDR,
   output logic [3:0]    ARLEN,
   output logic [2:0]    ARSIZE,
   output logic [1:0]    ARBURST,
   output logic          ARVALID,
   input  logic          ARREADY,
   input  logic [31:0]   RDATA,
   input  logic [1:0]    RRESP,
   input  logic          RLAST,
   input  logic          RVALID,
   output logic          RREADY
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RDTAG      = 4'd1,
      RDCHECK    = 4'd2,
      RDCACHE    = 4'd3,
      CACHETOCPU = 4'd4,
      RDUPCACHE  = 4'd5,
      SRAMTOCPU  = 4'd6,
      AR         = 4'd7,
      R_WAIT     = 4'd8,
      R          = 4'd9,
      R_HS       = 4'd10
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic            err_q;
   logic            beat_fire;
   logic            beat_end;
   logic            beat_bad;

   // A beat is taken whenever the bus offers data while we are collecting.
   assign beat_fire = RVALID && ((state == R_WAIT) || (state == R));
   // Burst ends on RLAST or on the fourth beat, whichever comes first.
   assign beat_end  = RLAST || (cnt == CW'(3));
   // Non-OKAY response, or RLAST not coinciding with the fourth beat.
   assign beat_bad  = (RRESP != 2'b00) || (RLAST != (cnt == CW'(3)));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      o_done    = 1'b0;
      o_inst    = '0;
      o_bus_err = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      case (state)
         IDLE: begin
            if (i_cpu_req) state_nxt = RDTAG;
         end
         RDTAG: begin
            state_nxt = RDCHECK;
         end
         RDCHECK: begin
            state_nxt = i_m0_hit ? RDCACHE : AR;
         end
         RDCACHE: begin
            state_nxt = CACHETOCPU;
         end
         CACHETOCPU: begin
            o_done    = 1'b1;
            o_inst    = i_cache_do[DW*o_cpu_a[3:2] +: DW];
            state_nxt = IDLE;
         end
         AR: begin
            ARVALID = 1'b1;
            if (ARREADY) state_nxt = R_WAIT;
         end
         R_WAIT: begin
            RREADY = 1'b1;
            if (RVALID) state_nxt = beat_end ? R_HS : R;
         end
         R: begin
            RREADY = 1'b1;
            if (RVALID && beat_end) state_nxt = R_HS;
         end
         R_HS: begin
            state_nxt = err_q ? SRAMTOCPU : RDUPCACHE;
         end
         RDUPCACHE: begin
            state_nxt = SRAMTOCPU;
         end
         SRAMTOCPU: begin
            o_done    = 1'b1;
            o_inst    = o_line[DW*o_cpu_a[3:2] +: DW];
            o_bus_err = err_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request address latch, line assembly, beat counter and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_cpu_a <= '0;
         o_line  <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state == IDLE) && i_cpu_req) begin
            o_cpu_a <= i_cpu_addr;
            err_q   <= 1'b0;
         end
         if ((state == AR) && ARREADY) cnt <= '0;
         if (beat_fire) begin
            o_line[DW*cnt +: DW] <= RDATA;
            cnt                  <= cnt + CW'(1);
            if (beat_bad) err_q <= 1'b1;
         end
      end
   end

   assign o_busy     = (state != IDLE);
   assign o_m0_state = state;
   assign ARID       = M0_ID;
   assign ARADDR     = {o_cpu_a[31:4], 4'b0000};
   assign ARLEN      = 4'd3;
   assign ARSIZE     = 3'b010;
   assign ARBURST    = 2'b01;

endmodule

// File: tb/tb_icache_m0_fill_ctrl.sv
// Bench for icache_m0_fill_ctrl: table of fetch transactions driven through
// a small AXI read slave, with expected completions held in a scoreboard.
`timescale 1ns/1ps
module tb_icache_m0_fill_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_cpu_req;
   logic [31:0]   i_cpu_addr;
   logic          o_done;
   logic [31:0]   o_inst;
   logic          o_busy;
   logic          o_bus_err;
   logic [3:0]    o_m0_state;
   logic [31:0]   o_cpu_a;
   logic          i_m0_hit;
   logic [127:0]  i_cache_do;
   logic [127:0]  o_line;
   logic [3:0]    ARID;
   logic [31:0]   ARADDR;
   logic [3:0]    ARLEN;
   logic [2:0]    ARSIZE;
   logic [1:0]    ARBURST;
   logic          ARVALID;
   logic          ARREADY;
   logic [31:0]   RDATA;
   logic [1:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY;

   always #5 clk = ~clk;

   icache_m0_fill_ctrl #(.M0_ID(4'd0)) dut (
      .clk(clk), .rst(rst),
      .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr),
      .o_done(o_done), .o_inst(o_inst), .o_busy(o_busy), .o_bus_err(o_bus_err),
      .o_m0_state(o_m0_state), .o_cpu_a(o_cpu_a),
      .i_m0_hit(i_m0_hit), .i_cache_do(i_cache_do), .o_line(o_line),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   // One fetch: stimulus plus the hand-derived expected outcome.
   typedef struct packed {
      logic [31:0]  addr;
      logic         hit;
      logic [127:0] cache_do;
      logic [127:0] beats;      // beat k in bits [32k+31:32k]
      logic [15:0]  gaps;       // idle cycles before beat k, 4 bits each
      logic [3:0]   ar_delay;   // cycles ARREADY held low
      logic [2:0]   err_beat;   // beat answered with SLVERR, 4 = none
      logic [2:0]   last_beat;  // beat carrying RLAST, 4 = never
      logic [2:0]   rst_after;  // assert reset after this beat, 7 = never
      logic [31:0]  exp_inst;
      logic         exp_err;
      logic [7:0]   exp_lat;
      logic [1:0]   exp_st5;
   } vec_t;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
      logic [7:0]  lat;
   } exp_t;

   localparam int NV = 10;
   vec_t vecs [NV];
   exp_t sb_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] ln(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic vec_t mk(input logic [31:0] addr, input logic hit,
                               input logic [127:0] cdo, input logic [127:0] beats,
                               input logic [15:0] gaps, input logic [3:0] ard,
                               input logic [2:0] eb, input logic [2:0] lb,
                               input logic [2:0] ra, input logic [31:0] ei,
                               input logic ee, input logic [7:0] el, input logic [1:0] e5);
      vec_t v;
      v.addr = addr;  v.hit = hit;  v.cache_do = cdo;  v.beats = beats;
      v.gaps = gaps;  v.ar_delay = ard;  v.err_beat = eb;  v.last_beat = lb;
      v.rst_after = ra;  v.exp_inst = ei;  v.exp_err = ee;  v.exp_lat = el;
      v.exp_st5 = e5;
      return v;
   endfunction

   task automatic bus_idle();
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RLAST   = 1'b0;
      RRESP   = 2'b00;
      RDATA   = 32'h0;
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, "_ctl"},
            128'({o_m0_state, o_busy, o_done, o_bus_err, ARVALID, RREADY, o_inst, o_cpu_a}),
            128'(0));
      check({nm, "_line"}, o_line, 128'(0));
   endtask

   // Runs one fetch cycle by cycle; we sit at posedge+1 on entry and exit.
   task automatic run_vec(input vec_t v, input int idx);
      bit   done_seen = 1'b0;
      bit   ar_done   = 1'b0;
      bit   r_phase   = 1'b0;
      bit   aborted   = 1'b0;
      bit   beat_now;
      int   b = 0, g = 0, ar_lo = 0, st5 = 0, arv = 0, nbeats;
      exp_t e;
      exp_t got;
      nbeats = (v.last_beat < 3'd4) ? int'(v.last_beat) + 1 : 4;
      for (int c = 0; c < 60 && !done_seen && !aborted; c++) begin
         bus_idle();
         beat_now = 1'b0;
         if (c == 0) begin
            i_cpu_req  = 1'b1;
            i_cpu_addr = v.addr;
            i_m0_hit   = v.hit;
            i_cache_do = v.cache_do;
            e.inst = v.exp_inst;  e.err = v.exp_err;  e.lat = v.exp_lat;
            sb_q.push_back(e);
         end else begin
            i_cpu_addr = $urandom();
         end
         if (v.rst_after != 3'd7 && b > int'(v.rst_after)) begin
            rst = 1'b1;
            #1;
            check_reset_vals($sformatf("v%0d_midrst", idx));
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            aborted = 1'b1;
         end else begin
            if (ARVALID) begin
               arv++;
               check($sformatf("v%0d_araddr", idx), 128'(ARADDR), 128'({v.addr[31:4], 4'h0}));
               check($sformatf("v%0d_arattr", idx), 128'({ARID, ARLEN, ARSIZE, ARBURST}),
                     128'({4'd0, 4'd3, 3'd2, 2'd1}));
               if (ar_lo < int'(v.ar_delay)) ar_lo++;
               else begin
                  ARREADY = 1'b1;
                  ar_done = 1'b1;
               end
            end else if (r_phase && b < nbeats) begin
               if (g < int'(v.gaps[4*b +: 4])) g++;
               else begin
                  RVALID   = 1'b1;
                  RDATA    = v.beats[32*b +: 32];
                  RRESP    = (b == int'(v.err_beat)) ? 2'b10 : 2'b00;
                  RLAST    = (b == int'(v.last_beat));
                  beat_now = 1'b1;
               end
            end
            #1;
            check($sformatf("v%0d_c%0d_rready", idx, c), 128'(RREADY),
                  128'(r_phase && b < nbeats));
            check($sformatf("v%0d_c%0d_busy", idx, c), 128'(o_busy), 128'(c != 0));
            if (o_m0_state == 4'd5) begin
               st5++;
               check($sformatf("v%0d_upd_line", idx), o_line, v.beats);
               check($sformatf("v%0d_upd_addr", idx), 128'(o_cpu_a), 128'(v.addr));
            end
            if (o_done) begin
               done_seen = 1'b1;
               if (sb_q.size() == 0) begin
                  check($sformatf("v%0d_sb_empty", idx), 128'(1), 128'(0));
               end else begin
                  got = sb_q.pop_front();
                  check($sformatf("v%0d_inst", idx), 128'(o_inst), 128'(got.inst));
                  check($sformatf("v%0d_buserr", idx), 128'(o_bus_err), 128'(got.err));
                  check($sformatf("v%0d_latency", idx), 128'(c), 128'(got.lat));
               end
            end else begin
               check($sformatf("v%0d_c%0d_inst0", idx, c), 128'({o_inst, o_bus_err}), 128'(0));
            end
            if (beat_now) begin
               b++;
               g = 0;
            end
            if (ar_done) r_phase = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      i_cpu_req = 1'b0;
      bus_idle();
      if (!aborted) begin
         check($sformatf("v%0d_timeout", idx), 128'(done_seen), 128'(1));
         check($sformatf("v%0d_st5_visits", idx), 128'(st5), 128'(v.exp_st5));
         check($sformatf("v%0d_arvalid_cycles", idx), 128'(arv),
               128'(v.hit ? 0 : int'(v.ar_delay) + 1));
      end
      rst = 1'b0;
      #1;
      check($sformatf("v%0d_idle_after", idx), 128'({o_busy, o_done}), 128'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      i_cpu_req  = 1'b0;
      i_cpu_addr = 32'h0;
      i_m0_hit   = 1'b0;
      i_cache_do = 128'h0;
      bus_idle();

      vecs[0] = mk(32'h0000_1008, 1'b0, 128'h0, ln(32'hA0, 32'hA1, 32'hA2, 32'hA3),
                   16'h0000, 4'd0, 3'd4, 3'd3, 3'd7, 32'hA2, 1'b0, 8'd10, 2'd1);
      vecs[1] = mk(32'h0000_100C, 1'b1, ln(32'hD0, 32'hD1, 32'hD2, 32'hD3), 128'h0,
                   16'h0000, 4'd0, 3'd4, 3'd3, 3'd7, 32'hD3, 1'b0, 8'd4, 2'd0);
      vecs[2] = mk(32'h0000_8004, 1'b0, 128'h0, ln(32'hB0, 32'hB1, 32'hB2, 32'hB3),
                   16'h0000, 4'd5, 3'd4, 3'd3, 3'd7, 32'hB1, 1'b0, 8'd15, 2'd1);
      vecs[3] = mk(32'h0000_3000, 1'b0, 128'h0, ln(32'hC0, 32'hC1, 32'hC2, 32'hC3),
                   16'h4020, 4'd0, 3'd4, 3'd3, 3'd7, 32'hC0, 1'b0, 8'd16, 2'd1);
      vecs[4] = mk(32'h0000_400C, 1'b0, 128'h0, ln(32'hE0, 32'hE1, 32'hE2, 32'hE3),
                   16'h0000, 4'd0, 3'd1, 3'd3, 3'd7, 32'hE3, 1'b1, 8'd9, 2'd0);
      vecs[5] = mk(32'h0000_1000, 1'b1, ln(32'h11, 32'h22, 32'h33, 32'h44), 128'h0,
                   16'h0000, 4'd0, 3'd4, 3'd3, 3'd7, 32'h11, 1'b0, 8'd4, 2'd0);
      vecs[6] = mk(32'h0000_5004, 1'b0, 128'h0, ln(32'hF0, 32'hF1, 32'hF2, 32'hF3),
                   16'h0000, 4'd0, 3'd4, 3'd2, 3'd7, 32'hF1, 1'b1, 8'd8, 2'd0);
      vecs[7] = mk(32'h0000_6008, 1'b0, 128'h0, ln(32'h60, 32'h61, 32'h62, 32'h63),
                   16'h0003, 4'd0, 3'd4, 3'd4, 3'd7, 32'h62, 1'b1, 8'd12, 2'd0);
      vecs[8] = mk(32'h0000_7000, 1'b0, 128'h0, ln(32'h70, 32'h71, 32'h72, 32'h73),
                   16'h0000, 4'd0, 3'd4, 3'd3, 3'd2, 32'h0, 1'b0, 8'd0, 2'd0);
      vecs[9] = mk(32'h0000_2000, 1'b0, 128'h0, ln(32'h20, 32'h21, 32'h22, 32'h23),
                   16'h0000, 4'd0, 3'd4, 3'd3, 3'd7, 32'h20, 1'b0, 8'd10, 2'd1);

      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("post_por");

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
